// File: rtl/bus_responder_pkg.sv
// Shared constants and types for the bus responder: bus/address widths,
// default LED address and the bus-source selector used by the output driver.
package bus_responder_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;
    localparam int unsigned MAX_BTN   = 8;

    localparam logic [ADDR_W-1:0] LED_ADDR_DEFAULT = 8'hF0;

    // Status byte layout: pressed flags in the low bits, zeros above.
    localparam int unsigned STATUS_LSB = 0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_BTN  = 2'd2
    } bus_src_e;

endpackage

// File: rtl/bus_responder_btn_latch.sv
// Button front end: two-flop synchronizer, rising-edge detect and a sticky
// pressed flag per bit, cleared by a read-to-clear strobe.
module btn_latch #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_in,
    input  logic             clr,
    output logic [WIDTH-1:0] pressed
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_hist;
    logic [WIDTH-1:0] r_pressed;
    logic [WIDTH-1:0] w_rise;

    assign w_rise = r_sync2 & ~r_hist;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, which the synchronizer
    // chain depends on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_hist    <= '0;
            r_pressed <= '0;
        end else begin
            r_sync1   <= btn_in;
            r_sync2   <= r_sync1;
            r_hist    <= r_sync2;
            // An edge arriving on the clearing edge wins over the clear.
            r_pressed <= (clr ? '0 : r_pressed) | w_rise;
        end
    end

    assign pressed = r_pressed;

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped responder on a shared tri-state bus: 256x8 RAM, LED register
// shadowing one address, and a read-to-clear button status byte.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter string             INIT_FILE = "",
    parameter logic [ADDR_W-1:0] LED_ADDR  = LED_ADDR_DEFAULT,
    parameter int                NUM_BTN   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic              c_ri,
    input  logic              c_ro,
    input  logic              mem_clk,
    input  logic              button_read,
    inout  wire  [DATA_W-1:0] bus,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [DATA_W-1:0] led_out,
    output logic              bus_err
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_led;
    logic              r_bus_err;

    logic              w_illegal;
    logic              w_wr_en;
    logic              w_clr;
    logic [NUM_BTN-1:0] w_pressed;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_drive_data;
    bus_src_e          w_src;

    // Write strobe is qualified by reset so a write caught by reset is dropped.
    assign w_illegal = mem_clk & c_ri & (c_ro | button_read);
    assign w_wr_en   = reset & mem_clk & c_ri & ~c_ro & ~button_read;
    assign w_clr     = mem_clk & button_read & ~c_ri;

    btn_latch #(
        .WIDTH (NUM_BTN)
    ) u_btn_latch (
        .clk     (clk),
        .reset   (reset),
        .btn_in  (btn_in),
        .clr     (w_clr),
        .pressed (w_pressed)
    );

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_status = '0;
        w_status[STATUS_LSB +: NUM_BTN] = w_pressed;
    end

    always_comb begin
        w_src = SRC_NONE;
        if (!reset) begin
            w_src = SRC_NONE;
        end else if (button_read && !(c_ri && mem_clk)) begin
            w_src = SRC_BTN;
        end else if (c_ro && !c_ri && !button_read) begin
            w_src = SRC_RAM;
        end
    end

    assign w_rd_data = r_mem[addr_bus];

    always_comb begin
        w_drive_data = '0;
        unique case (w_src)
            SRC_RAM: w_drive_data = w_rd_data;
            SRC_BTN: w_drive_data = w_status;
            default: w_drive_data = '0;
        endcase
    end

    assign bus = (w_src == SRC_NONE) ? {DATA_W{1'bz}} : w_drive_data;

    // NOTE: the RAM array has no reset; contents survive reset and map onto
    // block RAM, which cannot be cleared in one cycle anyway.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[addr_bus] <= bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_wr_en && (addr_bus == LED_ADDR)) begin
                r_led <= bus;
            end
            if (w_illegal) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign led_out = r_led;
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: RAM model plus expected-value queue
// for every bus observation; undriven bus reads back as 8'hFF via tri1.
module tb_bus_responder;
    import bus_responder_pkg::*;

    logic       clk         = 1'b0;
    logic       reset       = 1'b0;
    logic [7:0] addr_bus    = 8'h00;
    logic       c_ri        = 1'b0;
    logic       c_ro        = 1'b0;
    logic       mem_clk     = 1'b0;
    logic       button_read = 1'b0;
    logic [3:0] btn_in      = 4'h0;
    logic [7:0] led_out;
    logic       bus_err;

    tri1  [7:0] bus;
    logic       tb_drv  = 1'b0;
    logic [7:0] tb_data = 8'h00;
    assign bus = tb_drv ? tb_data : 8'bz;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];
    logic [7:0] model_mem [logic [7:0]];

    localparam logic [7:0] Z_VAL = 8'hFF;

    bus_responder #(
        .INIT_FILE (""),
        .LED_ADDR  (8'hF0),
        .NUM_BTN   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_bus    (addr_bus),
        .c_ri        (c_ri),
        .c_ro        (c_ro),
        .mem_clk     (mem_clk),
        .button_read (button_read),
        .bus         (bus),
        .btn_in      (btn_in),
        .led_out     (led_out),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic sample_bus(input string tag);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got empty-queue expected entry", tag);
        end else begin
            check(tag, bus, exp_q.pop_front());
        end
    endtask

    task automatic idle();
        c_ri        = 1'b0;
        c_ro        = 1'b0;
        mem_clk     = 1'b0;
        button_read = 1'b0;
        tb_drv      = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        idle();
        addr_bus = a;
        tb_data  = d;
        tb_drv   = 1'b1;
        c_ri     = 1'b1;
        mem_clk  = 1'b1;
        model_mem[a] = d;
        @(negedge clk);
        idle();
    endtask

    task automatic read_ram(input string tag, input logic [7:0] a);
        @(negedge clk);
        idle();
        addr_bus = a;
        c_ro     = 1'b1;
        exp_q.push_back(model_mem[a]);
        sample_bus(tag);
    endtask

    task automatic read_btn(input string tag, input logic [7:0] exp, input logic clr);
        @(negedge clk);
        idle();
        button_read = 1'b1;
        mem_clk     = clr;
        exp_q.push_back(exp);
        sample_bus(tag);
    endtask

    initial begin
        logic [7:0] addrs [4];
        addrs = '{8'h00, 8'h7F, 8'hFF, 8'h42};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_led", led_out, 8'h00);
        check("rst_err", {7'b0, bus_err}, 8'h00);
        exp_q.push_back(Z_VAL);
        sample_bus("rst_bus_z");
        @(negedge clk);
        reset = 1'b1;

        // Write/read, high-Z when idle
        do_write(8'h10, 8'hA5);
        addr_bus = 8'h10;
        exp_q.push_back(Z_VAL);
        sample_bus("idle_bus_z");
        read_ram("rd_10", 8'h10);
        for (int i = 0; i < 4; i++) begin
            do_write(addrs[i], 8'($urandom_range(0, 254)));
        end
        for (int i = 0; i < 4; i++) begin
            read_ram($sformatf("rd_%02h", addrs[i]), addrs[i]);
        end

        // LED register
        do_write(8'hF0, 8'h3C);
        check("led_set", led_out, 8'h3C);
        read_ram("rd_f0", 8'hF0);
        do_write(8'hF1, 8'h99);
        check("led_hold", led_out, 8'h3C);

        // Button 2: three-clock latency, priority over c_ro, read-to-clear
        @(negedge clk);
        btn_in[2] = 1'b1;
        @(negedge clk);
        read_btn("btn2_early", 8'h00, 1'b0);
        @(negedge clk);
        idle();
        btn_in[2]   = 1'b0;
        addr_bus    = 8'h10;
        c_ro        = 1'b1;
        button_read = 1'b1;
        exp_q.push_back(8'h04);
        sample_bus("btn2_prio");
        read_btn("btn2_clr", 8'h04, 1'b1);
        read_btn("btn2_after", 8'h00, 1'b0);

        // Collision: clear edge coincides with a new bit-0 edge
        @(negedge clk);
        btn_in = 4'b1010;
        repeat (3) @(negedge clk);
        btn_in = 4'b0000;
        read_btn("btn_multi", 8'h0A, 1'b0);
        @(negedge clk);
        btn_in[0] = 1'b1;
        @(negedge clk);
        read_btn("coll_pre", 8'h0A, 1'b1);
        read_btn("coll_post", 8'h01, 1'b0);
        read_btn("coll_clr", 8'h01, 1'b1);
        read_btn("coll_empty", 8'h00, 1'b0);
        @(negedge clk);
        btn_in = 4'b0000;

        // Illegal strobe combinations
        do_write(8'h30, 8'h5A);
        @(negedge clk);
        idle();
        addr_bus = 8'h30;
        c_ri     = 1'b1;
        c_ro     = 1'b1;
        mem_clk  = 1'b1;
        exp_q.push_back(Z_VAL);
        sample_bus("ill_ro_z");
        @(negedge clk);
        idle();
        check("ill_err", {7'b0, bus_err}, 8'h01);
        read_ram("ill_ram", 8'h30);
        @(negedge clk);
        idle();
        c_ri        = 1'b1;
        button_read = 1'b1;
        mem_clk     = 1'b1;
        exp_q.push_back(Z_VAL);
        sample_bus("ill_btn_z");
        repeat (3) @(negedge clk);
        idle();
        check("ill_sticky", {7'b0, bus_err}, 8'h01);

        // Reset in the middle of a write
        @(negedge clk);
        btn_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        btn_in[3] = 1'b0;
        read_btn("pre_rst_btn", 8'h08, 1'b0);
        do_write(8'h20, 8'h11);
        @(negedge clk);
        idle();
        addr_bus = 8'h20;
        tb_data  = 8'h77;
        tb_drv   = 1'b1;
        c_ri     = 1'b1;
        mem_clk  = 1'b1;
        reset    = 1'b0;
        #1;
        check("mid_rst_led", led_out, 8'h00);
        check("mid_rst_err", {7'b0, bus_err}, 8'h00);
        @(negedge clk);
        idle();
        addr_bus = 8'h20;
        c_ro     = 1'b1;
        exp_q.push_back(Z_VAL);
        sample_bus("rst_ro_z");
        @(negedge clk);
        idle();
        reset = 1'b1;
        read_ram("rst_ram", 8'h20);
        read_btn("rst_btn", 8'h00, 1'b0);
        check("post_rst_led", led_out, 8'h00);
        check("post_rst_err", {7'b0, bus_err}, 8'h00);

        @(negedge clk);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
